rx_iq_buffer: RTL

- Sits between the DDC decimation/FIR output and the I2S transmitter, in the DDC clock domain.
- Accepts strobed 24-bit I/Q samples and applies a saturating power-of-two gain.
- Buffers samples in a small FIFO and presents one held I/Q pair per I2S frame on the rx_real/rx_imag bus that the I2S block samples.
- Reports FIFO overflow and underrun so firmware can detect a sample-rate mismatch.

---
 rtl/rx_iq_buffer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rx_iq_buffer.sv
// DDC-to-I2S sample buffer: saturating power-of-two gain, small I/Q FIFO, and one held
// I/Q pair per LRCLK frame, with overflow/underrun event counters.
module rx_iq_buffer #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned W          = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [W-1:0]          in_real,
  input  logic [W-1:0]          in_imag,
  input  logic [2:0]            gain,
  input  logic                  lrclk,
  output logic [W-1:0]          rx_real,
  output logic [W-1:0]          rx_imag,
  output logic [DEPTH_LOG2:0]   level,
  output logic [7:0]            ovf_cnt,
  output logic [7:0]            unf_cnt,
  input  logic                  clr_cnt
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic signed [W+6:0]   MAX_EXT  = {{8{1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [W+6:0]   MIN_EXT  = {{8{1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0]          SAT_POS  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]          SAT_NEG  = {1'b1, {(W-1){1'b0}}};

  // W+7 bits holds any 7-bit left shift of a W-bit value exactly, so clamping is lossless.
  function automatic logic [W-1:0] sat_shift(input logic [W-1:0] x, input logic [2:0] sh);
    logic signed [W+6:0] v;
    v = $signed({{7{x[W-1]}}, x}) <<< sh;
    if (v > MAX_EXT)      return SAT_POS;
    else if (v < MIN_EXT) return SAT_NEG;
    else                  return v[W-1:0];
  endfunction

  logic                  r_push;
  logic [W-1:0]          r_g_real;
  logic [W-1:0]          r_g_imag;
  logic                  r_lrclk_prev;
  logic [2*W-1:0]        r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [W-1:0]          r_rx_real;
  logic [W-1:0]          r_rx_imag;
  logic [7:0]            r_ovf;
  logic [7:0]            r_unf;

  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_do_write;
  logic w_do_read;
  logic w_ovf_evt;
  logic w_unf_evt;

  always_comb begin
    w_pop      = r_lrclk_prev & ~lrclk;
    w_full     = (r_level == LVL_FULL);
    w_empty    = (r_level == '0);
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts the push.
    w_do_write = r_push & (~w_full | w_pop);
    w_do_read  = w_pop & ~w_empty;
    w_ovf_evt  = r_push & w_full & ~w_pop;
    w_unf_evt  = w_pop & w_empty;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_push       <= 1'b0;
      r_g_real     <= '0;
      r_g_imag     <= '0;
      r_lrclk_prev <= 1'b1;
    end else begin
      r_push       <= in_valid;
      r_g_real     <= sat_shift(in_real, gain);
      r_g_imag     <= sat_shift(in_imag, gain);
      r_lrclk_prev <= lrclk;
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_write) r_mem[r_wptr] <= {r_g_real, r_g_imag};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_rx_real <= '0;
      r_rx_imag <= '0;
    end else begin
      if (w_do_write) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_read) begin
        r_rptr                 <= r_rptr + PTR_ONE;
        {r_rx_real, r_rx_imag} <= r_mem[r_rptr];
      end
      case ({w_do_write, w_do_read})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ovf <= '0;
      r_unf <= '0;
    end else if (clr_cnt) begin
      r_ovf <= '0;
      r_unf <= '0;
    end else begin
      if (w_ovf_evt && r_ovf != 8'hFF) r_ovf <= r_ovf + 8'd1;
      if (w_unf_evt && r_unf != 8'hFF) r_unf <= r_unf + 8'd1;
    end
  end

  assign rx_real = r_rx_real;
  assign rx_imag = r_rx_imag;
  assign level   = r_level;
  assign ovf_cnt = r_ovf;
  assign unf_cnt = r_unf;

endmodule
